mest_run_controller: RTL and testbench

- Synthesizable host-side counterpart of mest_pro's control/result interface; it plays the role the stimulus module plays in simulation.
- Sequences a program run: memory reset, then start pulse, then result capture, then completion or timeout.
- Buffers each valid result with its flags in a FIFO that the host drains over a valid/ready read port.
- Sits between a host/UART bridge and mest_pro; drives i_start/i_memory_reset and consumes o_result/o_valid_result/o_carry/o_zero_flag/o_all_done.

---
 rtl/mest_run_pkg.sv | 32 +++
 rtl/mest_result_fifo.sv | 70 +++++++
 rtl/mest_run_controller.sv | 179 +++++++++++++++++
 tb/tb_mest_run_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mest_run_pkg.sv
// Shared constants for the mest_pro run controller: FSM encoding and the
// layout of a captured FIFO entry {carry, zero, result}.
package mest_run_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_MEM_RST = 3'd1;
  localparam state_t ST_START   = 3'd2;
  localparam state_t ST_RUN     = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  localparam int RESULT_WIDTH_DEF = 8;
  localparam int ENTRY_WIDTH_DEF  = RESULT_WIDTH_DEF + 2;

  // Flag offsets above the result field
  localparam int ZERO_OFS  = 0;
  localparam int CARRY_OFS = 1;

  function automatic int entry_width(input int result_width);
    return result_width + 2;
  endfunction

  function automatic int zero_pos(input int result_width);
    return result_width + ZERO_OFS;
  endfunction

  function automatic int carry_pos(input int result_width);
    return result_width + CARRY_OFS;
  endfunction

endpackage

// File: rtl/mest_result_fifo.sv
// First-word fall-through capture FIFO; head data is driven straight from
// storage registers and reads as zero while empty.
module mest_result_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign count     = count_r;
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full | do_pop_s);

  // Head word, forced to zero when nothing is buffered
  always_comb begin
    rdata = {WIDTH{1'b0}};
    if (!empty) begin
      rdata = mem_r[rd_ptr_r];
    end else begin
      rdata = {WIDTH{1'b0}};
    end
  end

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mest_run_controller.sv
// Host-side run sequencer for mest_pro: memory reset, start pulse, result
// capture into a FIFO, then completion or timeout.
module mest_run_controller
  import mest_run_pkg::*;
#(
  parameter int RESULT_WIDTH   = 8,
  parameter int DEPTH          = 16,
  parameter int MEM_RST_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk,
  input  logic                          i_reset,
  input  logic                          i_go,
  output logic                          o_memory_reset,
  output logic                          o_start,
  input  logic [RESULT_WIDTH-1:0]       i_result,
  input  logic                          i_valid_result,
  input  logic                          i_carry,
  input  logic                          i_zero_flag,
  input  logic                          i_all_done,
  output logic [RESULT_WIDTH+1:0]       o_rd_data,
  output logic                          o_rd_valid,
  input  logic                          i_rd_ready,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_timeout,
  output logic                          o_overflow,
  output logic [$clog2(DEPTH*256)-1:0]  o_result_count
);

  localparam int EW  = entry_width(RESULT_WIDTH);
  localparam int CW  = $clog2(DEPTH * 256);
  localparam int MW  = $clog2(MEM_RST_CYCLES + 1);
  localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCW = $clog2(DEPTH) + 1;
  localparam int CARRY_BIT = carry_pos(RESULT_WIDTH);
  localparam int ZERO_BIT  = zero_pos(RESULT_WIDTH);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [MW-1:0]   mem_cnt_r;
  logic [TW-1:0]   run_cnt_r;
  logic            timeout_hit_s;
  logic            launch_s;
  logic            capture_s;
  logic            drop_s;
  logic            timeout_r;
  logic            overflow_r;
  logic [CW-1:0]   count_r;
  logic            mem_reset_r;
  logic            start_r;
  logic            busy_r;
  logic            done_r;

  logic            fifo_push_s;
  logic            fifo_pop_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [FCW-1:0]  fifo_count_s;
  logic [EW-1:0]   fifo_wdata_s;
  logic [EW-1:0]   fifo_rdata_s;

  assign launch_s    = ((state_r == ST_IDLE) || (state_r == ST_DONE)) && i_go;
  assign capture_s   = (state_r == ST_START) || (state_r == ST_RUN);
  assign fifo_pop_s  = ~fifo_empty_s & i_rd_ready;
  assign fifo_push_s = capture_s & i_valid_result & (~fifo_full_s | fifo_pop_s);
  assign drop_s      = capture_s & i_valid_result & fifo_full_s & ~fifo_pop_s;

  // Pack an incoming result with its flags
  always_comb begin
    fifo_wdata_s                     = {EW{1'b0}};
    fifo_wdata_s[RESULT_WIDTH-1:0]   = i_result;
    fifo_wdata_s[CARRY_BIT]          = i_carry;
    fifo_wdata_s[ZERO_BIT]           = i_zero_flag;
  end

  // Next-state decode; all_done takes priority over the timeout
  always_comb begin
    state_nxt_s   = state_r;
    timeout_hit_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (i_go) state_nxt_s = ST_MEM_RST;
        else      state_nxt_s = state_r;
      end
      ST_MEM_RST: begin
        if (mem_cnt_r == MW'(MEM_RST_CYCLES - 1)) state_nxt_s = ST_START;
        else                                      state_nxt_s = ST_MEM_RST;
      end
      ST_START: state_nxt_s = ST_RUN;
      ST_RUN: begin
        if (i_all_done) begin
          state_nxt_s = ST_DONE;
        end else if (run_cnt_r == TW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt_s   = ST_DONE;
          timeout_hit_s = 1'b1;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and per-phase cycle counters
  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_r   <= ST_IDLE;
      mem_cnt_r <= {MW{1'b0}};
      run_cnt_r <= {TW{1'b0}};
    end else begin
      state_r   <= state_nxt_s;
      mem_cnt_r <= ((state_r == ST_MEM_RST) && (state_nxt_s == ST_MEM_RST)) ?
                   mem_cnt_r + MW'(1) : {MW{1'b0}};
      run_cnt_r <= ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) ?
                   run_cnt_r + TW'(1) : {TW{1'b0}};
    end
  end

  // Sticky status and saturating accepted-result count, cleared on each launch
  always_ff @(posedge clk) begin
    if (i_reset) begin
      timeout_r  <= 1'b0;
      overflow_r <= 1'b0;
      count_r    <= {CW{1'b0}};
    end else if (launch_s) begin
      timeout_r  <= 1'b0;
      overflow_r <= 1'b0;
      count_r    <= {CW{1'b0}};
    end else begin
      if (timeout_hit_s) timeout_r <= 1'b1;
      if (drop_s)        overflow_r <= 1'b1;
      if (fifo_push_s && (count_r != {CW{1'b1}})) count_r <= count_r + CW'(1);
    end
  end

  // Control outputs registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (i_reset) begin
      mem_reset_r <= 1'b0;
      start_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      mem_reset_r <= (state_nxt_s == ST_MEM_RST);
      start_r     <= (state_nxt_s == ST_START);
      busy_r      <= (state_nxt_s == ST_MEM_RST) || (state_nxt_s == ST_START) ||
                     (state_nxt_s == ST_RUN);
      done_r      <= (state_nxt_s == ST_DONE);
    end
  end

  mest_result_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (i_reset),
    .clear (launch_s),
    .push  (fifo_push_s),
    .wdata (fifo_wdata_s),
    .pop   (fifo_pop_s),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign o_memory_reset = mem_reset_r;
  assign o_start        = start_r;
  assign o_busy         = busy_r;
  assign o_done         = done_r;
  assign o_timeout      = timeout_r;
  assign o_overflow     = overflow_r;
  assign o_result_count = count_r;
  assign o_rd_data      = fifo_rdata_s;
  assign o_rd_valid     = (fifo_count_s != {FCW{1'b0}});

endmodule

// File: tb/tb_mest_run_controller.sv
// Directed bench for mest_run_controller with a queue-based reference model
// compared every cycle, plus literal expectations from hand calculation.
module tb_mest_run_controller;

  localparam int RW      = 8;
  localparam int DEPTH   = 16;
  localparam int MEMC    = 4;
  localparam int TOC     = 32;
  localparam int CW      = $clog2(DEPTH * 256);
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam int P_IDLE = 0, P_MEM = 1, P_START = 2, P_RUN = 3, P_DONE = 4;

  logic          clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_go = 1'b0;
  logic          o_memory_reset, o_start;
  logic [RW-1:0] i_result = 8'h00;
  logic          i_valid_result = 1'b0, i_carry = 1'b0, i_zero_flag = 1'b0;
  logic          i_all_done = 1'b0;
  logic [RW+1:0] o_rd_data;
  logic          o_rd_valid;
  logic          i_rd_ready = 1'b0;
  logic          o_busy, o_done, o_timeout, o_overflow;
  logic [CW-1:0] o_result_count;

  int tests_run = 0;
  int tests_failed = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [RW+1:0] mq[$];
  int  ph = P_IDLE;
  int  mem_seen = 0, run_seen = 0;
  int  m_cnt = 0;
  bit  m_to = 1'b0, m_ov = 1'b0;
  int  pre_sz;
  bit  m_pop;

  mest_run_controller #(
    .RESULT_WIDTH   (RW),
    .DEPTH          (DEPTH),
    .MEM_RST_CYCLES (MEMC),
    .TIMEOUT_CYCLES (TOC)
  ) dut (
    .clk            (clk),
    .i_reset        (i_reset),
    .i_go           (i_go),
    .o_memory_reset (o_memory_reset),
    .o_start        (o_start),
    .i_result       (i_result),
    .i_valid_result (i_valid_result),
    .i_carry        (i_carry),
    .i_zero_flag    (i_zero_flag),
    .i_all_done     (i_all_done),
    .o_rd_data      (o_rd_data),
    .o_rd_valid     (o_rd_valid),
    .i_rd_ready     (i_rd_ready),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_timeout      (o_timeout),
    .o_overflow     (o_overflow),
    .o_result_count (o_result_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: advances on each edge from the inputs held during the cycle
  always @(posedge clk) begin
    pre_sz = mq.size();
    m_pop  = (pre_sz > 0) && i_rd_ready;
    if (i_reset) begin
      mq.delete();
      ph = P_IDLE; m_to = 1'b0; m_ov = 1'b0; m_cnt = 0;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if ((ph == P_START || ph == P_RUN) && i_valid_result) begin
        if (pre_sz < DEPTH || m_pop) begin
          mq.push_back({i_carry, i_zero_flag, i_result});
          if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
          m_ov = 1'b1;
        end
      end
      case (ph)
        P_IDLE, P_DONE: if (i_go) begin
          ph = P_MEM; mem_seen = 0;
          mq.delete(); m_to = 1'b0; m_ov = 1'b0; m_cnt = 0;
        end
        P_MEM: begin
          mem_seen++;
          if (mem_seen == MEMC) ph = P_START;
        end
        P_START: begin ph = P_RUN; run_seen = 0; end
        P_RUN: begin
          run_seen++;
          if (i_all_done) ph = P_DONE;
          else if (run_seen == TOC) begin ph = P_DONE; m_to = 1'b1; end
        end
        default: ph = P_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_memory_reset", {31'd0, o_memory_reset}, {31'd0, ph == P_MEM});
      check("m_start",        {31'd0, o_start},        {31'd0, ph == P_START});
      check("m_busy",         {31'd0, o_busy},  {31'd0, ph == P_MEM || ph == P_START || ph == P_RUN});
      check("m_done",         {31'd0, o_done},         {31'd0, ph == P_DONE});
      check("m_timeout",      {31'd0, o_timeout},      {31'd0, m_to});
      check("m_overflow",     {31'd0, o_overflow},     {31'd0, m_ov});
      check("m_count",        32'(o_result_count),     32'(m_cnt));
      check("m_rd_valid",     {31'd0, o_rd_valid},     {31'd0, mq.size() > 0});
      check("m_rd_data",      32'(o_rd_data),          (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
    end
  end

  // Launch a run and stop on the first RUN cycle, checking the launch clear
  task automatic start_run();
    i_go = 1'b1;
    step();
    i_go = 1'b0;
    check("launch_clear", {28'd0, o_timeout, o_overflow, o_rd_valid, o_result_count != 0}, 32'd0);
    repeat (5) step();
    check("run_busy", {31'd0, o_busy}, 32'd1);
  endtask

  task automatic drive_result(input logic [7:0] r, input logic c, input logic z);
    i_valid_result = 1'b1; i_result = r; i_carry = c; i_zero_flag = z;
  endtask

  initial begin
    int n;
    step();
    chk_en = 1'b1;
    check("reset_outputs", 32'({o_memory_reset, o_start, o_busy, o_done, o_timeout,
                                o_overflow, o_rd_valid, o_result_count, o_rd_data}), 32'd0);
    i_reset = 1'b0;

    // 1: launch sequence timing
    i_go = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      i_go = 1'b0;
      check("seq_memory_reset", {31'd0, o_memory_reset}, {31'd0, c <= 4});
      check("seq_start",        {31'd0, o_start},        {31'd0, c == 5});
      check("seq_busy",         {31'd0, o_busy},         32'd1);
    end

    // 2: three results then all_done, drained in order
    drive_result(8'h12, 1'b1, 1'b0); step();
    drive_result(8'h00, 1'b0, 1'b1); step();
    drive_result(8'hFF, 1'b0, 1'b0); step();
    i_valid_result = 1'b0; i_carry = 1'b0; i_zero_flag = 1'b0; i_all_done = 1'b1; step();
    i_all_done = 1'b0;
    check("t2_done",  {31'd0, o_done}, 32'd1);
    check("t2_count", 32'(o_result_count), 32'd3);
    check("t2_rd0",   32'(o_rd_data), 32'h212);
    i_rd_ready = 1'b1; step();
    check("t2_rd1",   32'(o_rd_data), 32'h100);
    step();
    check("t2_rd2",   32'(o_rd_data), 32'h0FF);
    step();
    i_rd_ready = 1'b0;
    check("t2_empty", {31'd0, o_rd_valid}, 32'd0);

    // 3: overflow at DEPTH, then a push accepted alongside a pop while full
    start_run();
    for (int k = 0; k < 18; k++) begin
      drive_result(8'h20 + 8'(k), 1'b0, 1'b0);
      step();
    end
    i_valid_result = 1'b0;
    check("t3_count",    32'(o_result_count), 32'd16);
    check("t3_overflow", {31'd0, o_overflow}, 32'd1);
    check("t3_head",     32'(o_rd_data), 32'h020);
    drive_result(8'h77, 1'b0, 1'b0); i_rd_ready = 1'b1; step();
    i_valid_result = 1'b0; i_rd_ready = 1'b0;
    check("t3_pop_push_count", 32'(o_result_count), 32'd17);
    check("t3_pop_push_head",  32'(o_rd_data), 32'h021);
    i_all_done = 1'b1; step();
    i_all_done = 1'b0;

    // 4: timeout after exactly TOC RUN cycles, cleared by the next launch
    start_run();
    n = 0;
    while (!o_done && n < 100) begin
      step();
      n++;
    end
    check("t4_run_cycles", 32'(n), 32'd32);
    check("t4_timeout",    {31'd0, o_timeout}, 32'd1);
    start_run();

    // 5: reset mid-run with buffered entries
    for (int k = 0; k < 5; k++) begin
      drive_result(8'h40 + 8'(k), 1'b1, 1'b1);
      step();
    end
    i_valid_result = 1'b0;
    check("t5_buffered", {31'd0, o_rd_valid}, 32'd1);
    i_reset = 1'b1; step();
    check("t5_reset_outputs", 32'({o_memory_reset, o_start, o_busy, o_done, o_timeout,
                                   o_overflow, o_rd_valid, o_result_count, o_rd_data}), 32'd0);
    i_reset = 1'b0;

    // 6: valid result and all_done in the same cycle
    start_run();
    drive_result(8'h55, 1'b0, 1'b0); i_all_done = 1'b1; step();
    i_valid_result = 1'b0; i_all_done = 1'b0;
    check("t6_done",  {31'd0, o_done}, 32'd1);
    check("t6_count", 32'(o_result_count), 32'd1);
    check("t6_data",  32'(o_rd_data), 32'h055);

    // all_done on the final RUN cycle beats the timeout
    start_run();
    repeat (TOC - 1) step();
    i_all_done = 1'b1; step();
    i_all_done = 1'b0;
    check("t7_done",    {31'd0, o_done}, 32'd1);
    check("t7_timeout", {31'd0, o_timeout}, 32'd0);

    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
